router_arbiter: RTL and testbench
=================================

// Module: router_arbiter
// PURPOSE
//  Shares one router instance between N_REQ independent requesters. Each requester issues
//  {cond_sel, opcode, op_a, op_b} and gets its 32-bit result back on its own response strobe.
//  Round-robin arbitration, one operation in flight, watchdog for a router that never completes.
//  Sits between the benchmark/host sequencers and the router's start/busy/done interface.
// PARAMETERS
//  N_REQ        4    number of requesters (2..8)
//  TIMEOUT_CYC  64   WAIT cycles before an operation is abandoned (>=2)
//  ERR_RESULT   32'hDEAD_BEEF  result returned on timeout
// PORTS
//  clk          in   1        clock
//  rst          in   1        synchronous reset, active-high
//  req_valid    in   N_REQ    request pending, per requester
//  req_ready    out  N_REQ    one-hot accept strobe; fields consumed when valid&ready
//  req_cond     in   2*N_REQ  cond_sel per requester, slice i = [2i+1:2i]
//  req_opcode   in   4*N_REQ  opcode per requester (common_opcodes.vh)
//  req_a        in   16*N_REQ operand A per requester
//  req_b        in   16*N_REQ operand B per requester
//  rsp_valid    out  N_REQ    one-hot, 1-cycle response strobe (no backpressure)
//  rsp_result   out  32       result, valid with rsp_valid
//  rsp_err      out  1        1 = timeout, rsp_result = ERR_RESULT
//  m_start      out  1        router start pulse
//  m_cond       out  2        router cond_sel
//  m_opcode     out  4        router opcode
//  m_a, m_b     out  16 each  router operands
//  m_busy       in   1        router busy
//  m_done       in   1        router done (1-cycle)
//  m_result     in   32       router result
//  ops_done     out  16       completed operations counter (incl. errors), wraps at 2^16
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, all outputs 0 (req_ready, rsp_valid, rsp_err, m_* , ops_done).
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; DRAIN entered only from WAIT on timeout.
//  IDLE: if any req_valid, winner w = first set bit at or after rr_ptr, wrapping at N_REQ-1->0.
//   req_ready[w]=1 combinationally that cycle; latch cond/opcode/a/b into m_* regs, go ISSUE.
//   No req_valid: stay. req_ready is 0 in every other state.
//  ISSUE: if m_busy=0 assert m_start for exactly one cycle (registered), clear wdog, go WAIT;
//   if m_busy=1 hold in ISSUE with m_start=0. m_* operand regs hold stable until next IDLE grant.
//  WAIT: wdog++ each cycle. m_done=1 -> capture m_result, rsp_err=0, go RESP (done wins over
//   timeout in the same cycle). wdog reaches TIMEOUT_CYC-1 without done -> result=ERR_RESULT,
//   rsp_err=1, go RESP with drain flag set.
//  RESP: rsp_valid[w]=1, rsp_result/rsp_err driven for one cycle; ops_done++; rr_ptr <= w+1
//   (wrap to 0). drain flag clear -> IDLE; set -> DRAIN.
//  DRAIN: wait until m_busy=0 and no m_done this cycle; any late m_done is discarded; -> IDLE.
//  Throughput: min 4 cycles arbiter overhead per op plus router latency.
//  Requester changing fields while valid and not ready: allowed; sampled only on grant.
//  Reset mid-operation: immediate return to reset values; in-flight result never reported.
//  Never more than one m_start outstanding; m_start never asserted while m_busy=1.
// STRUCTURE
//  Opcode and cond_sel encodings from common_opcodes.vh; add ARB state encodings there as
//  localparams only if shared with the bench. One sub-module: rr_pick (N_REQ-wide round-robin
//  priority picker: inputs req vector + ptr, outputs one-hot grant + index, combinational).
// TESTING (bench uses a behavioural router stub with programmable latency)
//  1 Single req0 BIN_ADD 1000,1234, stub lat 3 -> one m_start, rsp_valid=4'b0001, result 2234.
//  2 req0 BIN_ADD 1000,1234 and req1 BIN_SUB 3000,1234 same cycle -> req0 first (2234), then
//    req1 (1766); rr_ptr=2 after.
//  3 All 4 req_valid held high 12 ops -> grant order 0,1,2,3,0,1,2,3,... no starvation.
//  4 rr_ptr=2, only req1 valid -> wrap, req1 granted; rsp_valid=4'b0010.
//  5 Stub never asserts done, TIMEOUT_CYC=64 -> rsp_err=1, result 32'hDEAD_BEEF 64 cycles after
//    start; late done in DRAIN ignored; next request served normally.
//  6 rst asserted in WAIT -> all outputs 0 next cycle, no rsp_valid; ops_done=0.

Source files
------------

// File: rtl/router_arbiter_pkg.sv
// Shared types and constants for the router arbiter: FSM states, debug view,
// the opcode subset the benchmarks use, and the round-robin pointer helper.
package router_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE  = 3'd0,
    ARB_ISSUE = 3'd1,
    ARB_WAIT  = 3'd2,
    ARB_RESP  = 3'd3,
    ARB_DRAIN = 3'd4
  } arb_state_e;

  typedef struct packed {
    arb_state_e  state;
    logic [2:0]  rr_ptr;
  } arb_dbg_t;

  localparam logic [3:0] OP_BIN_ADD = 4'h0;
  localparam logic [3:0] OP_BIN_SUB = 4'h1;

  localparam logic [1:0] COND_ALWAYS = 2'd0;

  // Pointer moves to the slot after the winner, wrapping at n-1.
  function automatic logic [2:0] next_ptr(input logic [2:0] w, input int n);
    return (int'(w) >= n - 1) ? 3'd0 : w + 3'd1;
  endfunction

endpackage

// File: rtl/router_arbiter_if.sv
// Requester and router-side signals of the arbiter. master = arbiter view,
// slave = environment view (requesters plus the router instance).
// Handshake: a request field set is consumed on the cycle req_valid[i] & req_ready[i];
// rsp_valid is a one-cycle strobe with no backpressure.
interface router_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [2*N_REQ-1:0]  req_cond;
    logic [4*N_REQ-1:0]  req_opcode;
    logic [16*N_REQ-1:0] req_a;
    logic [16*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]    rsp_valid;
    logic [31:0]         rsp_result;
    logic                rsp_err;
    logic                m_start;
    logic [1:0]          m_cond;
    logic [3:0]          m_opcode;
    logic [15:0]         m_a;
    logic [15:0]         m_b;
    logic                m_busy;
    logic                m_done;
    logic [31:0]         m_result;

    modport master (
        input  req_valid, req_cond, req_opcode, req_a, req_b, m_busy, m_done, m_result,
        output req_ready, rsp_valid, rsp_result, rsp_err,
               m_start, m_cond, m_opcode, m_a, m_b
    );

    modport slave (
        output req_valid, req_cond, req_opcode, req_a, req_b, m_busy, m_done, m_result,
        input  req_ready, rsp_valid, rsp_result, rsp_err,
               m_start, m_cond, m_opcode, m_a, m_b
    );
endinterface

// File: rtl/router_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping from N_REQ-1 back to 0.
module router_arbiter_rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       ptr,
    output logic [N_REQ-1:0] grant,
    output logic [2:0]       idx,
    output logic             any
);
    int   j;
    logic found;

    assign any = |req;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = 3'(j);
            end
        end
    end
endmodule

// File: rtl/router_arbiter.sv
// Shares one router between N_REQ requesters: round-robin grant, one operation
// in flight, watchdog that returns ERR_RESULT and drains a router that never finishes.
module router_arbiter
    import router_arbiter_pkg::*;
#(
    parameter int          N_REQ       = 4,
    parameter int          TIMEOUT_CYC = 64,
    parameter logic [31:0] ERR_RESULT  = 32'hDEAD_BEEF
) (
    input  logic                clk,
    input  logic                rst,
    router_arbiter_if.master    bus,
    output logic [15:0]         ops_done,
    output arb_dbg_t            dbg
);
    localparam int             WD      = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD-1:0]  WD_LAST = WD'(TIMEOUT_CYC - 1);

    arb_state_e        state, state_nx;
    logic [2:0]        rr_ptr, win_q;
    logic [WD-1:0]     wdog;
    logic [31:0]       result_q;
    logic              err_q, drain_q, m_start_q;
    logic [1:0]        m_cond_q;
    logic [3:0]        m_opcode_q;
    logic [15:0]       m_a_q, m_b_q;
    logic [N_REQ-1:0]  pick_grant;
    logic [2:0]        pick_idx;
    logic              pick_any;

    router_arbiter_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ARB_IDLE:  if (pick_any) state_nx = ARB_ISSUE;
            ARB_ISSUE: if (!bus.m_busy) state_nx = ARB_WAIT;
            ARB_WAIT:  if (bus.m_done || wdog == WD_LAST) state_nx = ARB_RESP;
            ARB_RESP:  state_nx = drain_q ? ARB_DRAIN : ARB_IDLE;
            ARB_DRAIN: if (!bus.m_busy && !bus.m_done) state_nx = ARB_IDLE;
            default:   state_nx = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            rr_ptr     <= '0;
            win_q      <= '0;
            wdog       <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
            drain_q    <= 1'b0;
            m_start_q  <= 1'b0;
            m_cond_q   <= '0;
            m_opcode_q <= '0;
            m_a_q      <= '0;
            m_b_q      <= '0;
            ops_done   <= '0;
        end else begin
            state     <= state_nx;
            m_start_q <= (state == ARB_ISSUE) && !bus.m_busy;
            case (state)
                ARB_IDLE: if (pick_any) begin
                    win_q      <= pick_idx;
                    m_cond_q   <= bus.req_cond[{pick_idx, 1'b0} +: 2];
                    m_opcode_q <= bus.req_opcode[{pick_idx, 2'b00} +: 4];
                    m_a_q      <= bus.req_a[{pick_idx, 4'b0000} +: 16];
                    m_b_q      <= bus.req_b[{pick_idx, 4'b0000} +: 16];
                end
                ARB_ISSUE: if (!bus.m_busy) wdog <= '0;
                ARB_WAIT: begin
                    wdog <= wdog + 1'b1;
                    // A done arriving on the last watchdog cycle still counts as success.
                    if (bus.m_done) begin
                        result_q <= bus.m_result;
                        err_q    <= 1'b0;
                        drain_q  <= 1'b0;
                    end else if (wdog == WD_LAST) begin
                        result_q <= ERR_RESULT;
                        err_q    <= 1'b1;
                        drain_q  <= 1'b1;
                    end
                end
                ARB_RESP: begin
                    ops_done <= ops_done + 16'd1;
                    rr_ptr   <= next_ptr(win_q, N_REQ);
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = (state == ARB_IDLE) ? pick_grant : '0;
    assign bus.rsp_valid  = (state == ARB_RESP) ? ({{(N_REQ-1){1'b0}}, 1'b1} << win_q) : '0;
    assign bus.rsp_result = (state == ARB_RESP) ? result_q : '0;
    assign bus.rsp_err    = (state == ARB_RESP) && err_q;
    assign bus.m_start    = m_start_q;
    assign bus.m_cond     = m_cond_q;
    assign bus.m_opcode   = m_opcode_q;
    assign bus.m_a        = m_a_q;
    assign bus.m_b        = m_b_q;
    assign dbg            = '{state: state, rr_ptr: rr_ptr};
endmodule

// File: tb/tb_router_arbiter.sv
// Directed bench for router_arbiter with a behavioural router stub of programmable latency.
module tb_router_arbiter;
  import router_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [15:0] ops_done;
  arb_dbg_t   dbg;
  int         n_cmp = 0;
  int         n_err = 0;

  router_arbiter_if #(.N_REQ(4)) bus ();

  router_arbiter #(.N_REQ(4), .TIMEOUT_CYC(64), .ERR_RESULT(32'hDEAD_BEEF)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ops_done (ops_done),
    .dbg      (dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc_p = 0;
  always @(posedge clk) cyc_p <= cyc_p + 1;

  // router stub
  int          stub_lat = 3;
  bit          stub_hang = 1'b0;
  int          late_cmd = 0;
  int          late_seen = 0;
  int          start_cnt = 0;
  int          start_busy_cnt = 0;
  int          last_start_cyc = 0;
  int          s_cnt = 0;
  logic [3:0]  s_op;
  logic [15:0] s_a, s_b;

  always @(negedge clk) begin
    if (bus.m_start) begin
      start_cnt++;
      if (bus.m_busy) start_busy_cnt++;
      last_start_cyc = cyc_p;
    end
    if (rst) begin
      bus.m_busy = 1'b0; bus.m_done = 1'b0; bus.m_result = '0; s_cnt = 0;
    end else begin
      bus.m_done = 1'b0;
      if (late_cmd != late_seen) begin
        late_seen = late_cmd;
        bus.m_done = 1'b1; bus.m_busy = 1'b0; bus.m_result = 32'h0BAD_0BAD;
      end else if (bus.m_start) begin
        bus.m_busy = 1'b1; s_op = bus.m_opcode; s_a = bus.m_a; s_b = bus.m_b; s_cnt = stub_lat;
      end else if (bus.m_busy && !stub_hang) begin
        if (s_cnt <= 1) begin
          bus.m_done = 1'b1; bus.m_busy = 1'b0;
          bus.m_result = (s_op == OP_BIN_SUB) ? ({16'd0, s_a} - {16'd0, s_b})
                                              : ({16'd0, s_a} + {16'd0, s_b});
        end else s_cnt--;
      end
    end
  end

  // driver / checker tasks
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    bus.req_cond[2*i +: 2]   = COND_ALWAYS;
    bus.req_opcode[4*i +: 4] = op;
    bus.req_a[16*i +: 16]    = a;
    bus.req_b[16*i +: 16]    = b;
  endtask

  // Returns at the negedge of the response cycle; one-shot requesters drop valid once granted.
  task automatic wait_rsp(input int budget, input logic [3:0] oneshot, output logic [3:0] v,
                          output logic [31:0] r, output logic e, output int at_cyc);
    logic [3:0] g;
    v = '0; r = '0; e = 1'b0; at_cyc = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      g = bus.req_ready & bus.req_valid;
      if (bus.rsp_valid != '0) begin
        v = bus.rsp_valid; r = bus.rsp_result; e = bus.rsp_err; at_cyc = cyc_p;
        return;
      end
      @(posedge clk);
      #1 bus.req_valid = bus.req_valid & ~(g & oneshot);
    end
  endtask

  logic [3:0]  v;
  logic [31:0] r;
  logic        e;
  int          at;
  int          seen;
  logic [31:0] exp3 [4];

  initial begin
    bus.req_valid = '0; bus.req_cond = '0; bus.req_opcode = '0; bus.req_a = '0; bus.req_b = '0;
    exp3[0] = 32'd100; exp3[1] = 32'd201; exp3[2] = 32'd302; exp3[3] = 32'd403;

    // reset state
    do_reset();
    @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'h0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    check("rst_m_bus", {bus.m_start, bus.m_cond, bus.m_opcode, bus.m_a, bus.m_b}, 64'h0);
    check("rst_ops_done", 64'(ops_done), 64'h0);
    check("rst_state", 64'(dbg), 64'(arb_dbg_t'{state: ARB_IDLE, rr_ptr: 3'd0}));

    // 1: single req0 ADD 1000+1234, latency 3
    stub_lat = 3;
    set_req(0, OP_BIN_ADD, 16'd1000, 16'd1234);
    bus.req_valid = 4'b0001;
    wait_rsp(50, 4'b1111, v, r, e, at);
    check("t1_rsp_valid", 64'(v), 64'h1);
    check("t1_result", 64'(r), 64'd2234);
    check("t1_err", 64'(e), 64'h0);
    check("t1_m_a_held", 64'(bus.m_a), 64'd1000);
    check("t1_starts", 64'(start_cnt), 64'd1);
    @(posedge clk); #1;
    check("t1_ops_done", 64'(ops_done), 64'd1);
    check("t1_rr_ptr", 64'(dbg.rr_ptr), 64'd1);

    // 2: req0 and req1 together from rr_ptr=0
    do_reset();
    set_req(0, OP_BIN_ADD, 16'd1000, 16'd1234);
    set_req(1, OP_BIN_SUB, 16'd3000, 16'd1234);
    bus.req_valid = 4'b0011;
    wait_rsp(50, 4'b1111, v, r, e, at);
    check("t2_first_valid", 64'(v), 64'h1);
    check("t2_first_result", 64'(r), 64'd2234);
    wait_rsp(50, 4'b1111, v, r, e, at);
    check("t2_second_valid", 64'(v), 64'h2);
    check("t2_second_result", 64'(r), 64'd1766);
    @(posedge clk); #1;
    check("t2_rr_ptr", 64'(dbg.rr_ptr), 64'd2);
    check("t2_ops_done", 64'(ops_done), 64'd2);

    // 4: rr_ptr=2, only req1 valid -> wraps to req1
    set_req(1, OP_BIN_ADD, 16'd7, 16'd8);
    bus.req_valid = 4'b0010;
    wait_rsp(50, 4'b1111, v, r, e, at);
    check("t4_rsp_valid", 64'(v), 64'h2);
    check("t4_result", 64'(r), 64'd15);

    // 5: router hangs -> timeout 64 cycles after start, then drain with a late done
    stub_hang = 1'b1;
    set_req(3, OP_BIN_SUB, 16'd50, 16'd20);
    bus.req_valid = 4'b1000;
    wait_rsp(200, 4'b1111, v, r, e, at);
    check("t5_rsp_valid", 64'(v), 64'h8);
    check("t5_result", 64'(r), 64'hDEAD_BEEF);
    check("t5_err", 64'(e), 64'h1);
    check("t5_latency", 64'(at - last_start_cyc), 64'd64);
    @(posedge clk); #1;
    check("t5_drain_state", 64'(dbg.state), 64'(ARB_DRAIN));
    check("t5_ops_done", 64'(ops_done), 64'd4);
    late_cmd++;
    stub_hang = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid != '0) seen++;
    end
    check("t5_late_done_dropped", 64'(seen), 64'd0);
    check("t5_back_idle", 64'(dbg.state), 64'(ARB_IDLE));
    check("t5_ops_after_drain", 64'(ops_done), 64'd4);
    stub_lat = 2;
    set_req(2, OP_BIN_ADD, 16'd40, 16'd2);
    @(posedge clk); #1;
    bus.req_valid = 4'b0100;
    wait_rsp(50, 4'b1111, v, r, e, at);
    check("t5_next_valid", 64'(v), 64'h4);
    check("t5_next_result", 64'(r), 64'd42);
    check("t5_next_err", 64'(e), 64'h0);

    // 6: reset while in WAIT
    stub_lat = 10;
    set_req(0, OP_BIN_ADD, 16'd1, 16'd1);
    @(posedge clk); #1;
    bus.req_valid = 4'b0001;
    @(posedge clk); #1;
    bus.req_valid = 4'b0000;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (dbg.state == ARB_WAIT) begin
        seen = 1;
        break;
      end
    end
    check("t6_reached_wait", 64'(seen), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_result}, 64'h0);
    check("t6_m_bus", {bus.m_start, bus.m_cond, bus.m_opcode, bus.m_a, bus.m_b}, 64'h0);
    check("t6_ops_done", 64'(ops_done), 64'h0);
    check("t6_state", 64'(dbg), 64'(arb_dbg_t'{state: ARB_IDLE, rr_ptr: 3'd0}));
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.rsp_valid != '0) seen++;
    end
    check("t6_no_rsp", 64'(seen), 64'd0);

    // 3: all four held valid for 12 ops from rr_ptr=0
    stub_lat = 1;
    for (int i = 0; i < 4; i++) set_req(i, OP_BIN_ADD, 16'(100 * (i + 1)), 16'(i));
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 12; k++) begin
      wait_rsp(50, 4'b0000, v, r, e, at);
      check($sformatf("t3_grant_%0d", k), 64'(v), 64'(4'b0001 << (k % 4)));
      check($sformatf("t3_result_%0d", k), 64'(r), 64'(exp3[k % 4]));
    end
    bus.req_valid = 4'b0000;
    @(posedge clk); #1;
    check("t3_ops_done", 64'(ops_done), 64'd12);

    check("start_while_busy", 64'(start_busy_cnt), 64'd0);
    check("total_starts", 64'(start_cnt), 64'd19);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard stop in case a directed step never returns.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
